// File: rtl/dma_2d_burst_gen.sv
// dma_2d_burst_gen
// Turns a latched 2D transfer description (base, row width, row count,
// stride) into a stream of AXI burst commands over a valid/ready handshake.
// Rows are split at C_MAX_BURST_LEN beats and, when DMA_BURST_4K_SPLIT_EN is
// defined, at 4 KB address boundaries.
//
// Ports:
//   aclk, areset               clock, synchronous active-high reset
//   i_start                    start pulse (ignored while o_busy)
//   i_base_addr                byte address of row 0 (BPB-aligned)
//   i_img_width/height/stride  row bytes, row count, row-to-row byte distance
//   o_cmd_valid, i_cmd_ready   command handshake
//   o_cmd_addr, o_cmd_len      burst start address and AxLEN (beats-1)
//   o_cmd_last                 final command of the transfer
//   o_busy, o_done, o_err      status: in progress, completion pulse, config error
//
// Optional macro: DMA_BURST_4K_SPLIT_EN (adds the 4 KB boundary limit).
module dma_2d_burst_gen #(
    parameter int unsigned C_ADDR_WIDTH    = 32,
    parameter int unsigned C_DATA_WIDTH    = 32,
    parameter int unsigned C_MAX_BURST_LEN = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    i_start,
    input  logic [C_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]             i_img_width,
    input  logic [31:0]             i_img_height,
    input  logic [31:0]             i_img_stride,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [7:0]              o_cmd_len,
    output logic                    o_cmd_last,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int unsigned BPB      = C_DATA_WIDTH / 8;
    localparam int unsigned BPB_LOG2 = $clog2(BPB);
    localparam logic [31:0] MAX_BEATS  = 32'(C_MAX_BURST_LEN);
    localparam logic [31:0] WIDTH_MASK = 32'(BPB - 1);
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = C_ADDR_WIDTH'(BPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_ISSUE,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [C_ADDR_WIDTH-1:0] cfg_base;
    logic [31:0]             cfg_width;
    logic [31:0]             cfg_height;
    logic [31:0]             cfg_stride;

    logic [C_ADDR_WIDTH-1:0] row_addr;
    logic [C_ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]             row_beats_left;
    logic [31:0]             rows_left;
    logic [31:0]             cur_beats;

    logic [31:0]             beats;
    logic [31:0]             row_beats;
    logic [C_ADDR_WIDTH-1:0] next_row_addr;
    logic                    cfg_bad;

    always_comb begin
        cfg_bad = (cfg_width == '0) || (cfg_height == '0) ||
                  ((cfg_width & WIDTH_MASK) != '0) ||
                  ((cfg_base & ADDR_MASK) != '0);
        row_beats     = cfg_width >> BPB_LOG2;
        next_row_addr = row_addr + C_ADDR_WIDTH'(cfg_stride);
    end

    // Burst size: smallest of the max-burst limit, what is left of the row
    // and (optionally) the beats remaining before the next 4 KB boundary.
    always_comb begin
        beats = row_beats_left;
        if (beats > MAX_BEATS)
            beats = MAX_BEATS;
`ifdef DMA_BURST_4K_SPLIT_EN
        begin
            logic [31:0] beats_to_4k;
            beats_to_4k = 32'((13'h1000 - {1'b0, cur_addr[11:0]}) >> BPB_LOG2);
            if (beats > beats_to_4k)
                beats = beats_to_4k;
        end
`else
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_CHECK;
            S_CHECK: state_nxt = cfg_bad ? S_FIN : S_CALC;
            S_CALC:  state_nxt = S_ISSUE;
            S_ISSUE: if (i_cmd_ready) state_nxt = o_cmd_last ? S_FIN : S_CALC;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cfg_base       <= '0;
            cfg_width      <= '0;
            cfg_height     <= '0;
            cfg_stride     <= '0;
            row_addr       <= '0;
            cur_addr       <= '0;
            row_beats_left <= '0;
            rows_left      <= '0;
            cur_beats      <= '0;
            o_cmd_addr     <= '0;
            o_cmd_len      <= '0;
            o_cmd_last     <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        cfg_base   <= i_base_addr;
                        cfg_width  <= i_img_width;
                        cfg_height <= i_img_height;
                        cfg_stride <= i_img_stride;
                        o_err      <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        o_err <= 1'b1;
                    end else begin
                        row_addr       <= cfg_base;
                        cur_addr       <= cfg_base;
                        row_beats_left <= row_beats;
                        rows_left      <= cfg_height;
                    end
                end
                S_CALC: begin
                    o_cmd_addr <= cur_addr;
                    o_cmd_len  <= 8'(beats - 32'd1);
                    o_cmd_last <= (rows_left == 32'd1) && (beats == row_beats_left);
                    cur_beats  <= beats;
                end
                S_ISSUE: begin
                    if (i_cmd_ready) begin
                        // Row finished: jump to the next row start instead of
                        // advancing within the row.
                        if (row_beats_left == cur_beats) begin
                            rows_left      <= rows_left - 32'd1;
                            row_addr       <= next_row_addr;
                            cur_addr       <= next_row_addr;
                            row_beats_left <= row_beats;
                        end else begin
                            cur_addr       <= cur_addr + C_ADDR_WIDTH'(cur_beats * BPB);
                            row_beats_left <= row_beats_left - cur_beats;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_valid = (state == S_ISSUE);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_FIN);

endmodule

// File: tb/tb_dma_2d_burst_gen.sv
module tb_dma_2d_burst_gen;

  logic        aclk = 1'b0;
  logic        areset;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [31:0] i_img_width;
  logic [31:0] i_img_height;
  logic [31:0] i_img_stride;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic [31:0] o_cmd_addr;
  logic [7:0]  o_cmd_len;
  logic        o_cmd_last;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int tests  = 0;
  int failed = 0;

  always #5 aclk = ~aclk;

  dma_2d_burst_gen #(
    .C_ADDR_WIDTH    (32),
    .C_DATA_WIDTH    (32),
    .C_MAX_BURST_LEN (16)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_img_width  (i_img_width),
    .i_img_height (i_img_height),
    .i_img_stride (i_img_stride),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_ready  (i_cmd_ready),
    .o_cmd_addr   (o_cmd_addr),
    .o_cmd_len    (o_cmd_len),
    .o_cmd_last   (o_cmd_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] w,
                          input logic [31:0] h, input logic [31:0] s);
    @(negedge aclk);
    i_base_addr  = base;
    i_img_width  = w;
    i_img_height = h;
    i_img_stride = s;
    i_start      = 1'b1;
    @(negedge aclk);
    i_start      = 1'b0;
    i_base_addr  = 32'hDEAD_BEE0;
    i_img_width  = 32'd4;
    i_img_height = 32'd7;
    i_img_stride = 32'd4;
  endtask

  task automatic expect_cmd(input string tag, input logic [31:0] addr,
                            input logic [7:0] len, input logic last);
    bit found = 1'b0;
    for (int unsigned i = 0; i < 16 && !found; i++) begin
      @(negedge aclk);
      if (o_cmd_valid) found = 1'b1;
    end
    chk({tag, "_valid"}, 32'(found), 32'd1);
    chk({tag, "_addr"}, o_cmd_addr, addr);
    chk({tag, "_len"}, 32'(o_cmd_len), 32'(len));
    chk({tag, "_last"}, 32'(o_cmd_last), 32'(last));
  endtask

  task automatic expect_done(input string tag, input logic err);
    @(negedge aclk);
    chk({tag, "_done"}, 32'(o_done), 32'd1);
    chk({tag, "_fin_valid"}, 32'(o_cmd_valid), 32'd0);
    chk({tag, "_fin_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_fin_err"}, 32'(o_err), 32'(err));
    @(negedge aclk);
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_idle_err"}, 32'(o_err), 32'(err));
  endtask

  task automatic scen1(input string tag);
    i_cmd_ready = 1'b1;
    do_start(32'h1000, 32'd64, 32'd2, 32'd256);
    chk({tag, "_check_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_check_valid"}, 32'(o_cmd_valid), 32'd0);
    @(negedge aclk);
    chk({tag, "_calc_valid"}, 32'(o_cmd_valid), 32'd0);
    @(negedge aclk);
    chk({tag, "_n3_valid"}, 32'(o_cmd_valid), 32'd1);
    chk({tag, "_c0_addr"}, o_cmd_addr, 32'h1000);
    chk({tag, "_c0_len"}, 32'(o_cmd_len), 32'd15);
    chk({tag, "_c0_last"}, 32'(o_cmd_last), 32'd0);
    @(negedge aclk);
    chk({tag, "_gap_valid"}, 32'(o_cmd_valid), 32'd0);
    @(negedge aclk);
    chk({tag, "_c1_valid"}, 32'(o_cmd_valid), 32'd1);
    chk({tag, "_c1_addr"}, o_cmd_addr, 32'h1100);
    chk({tag, "_c1_len"}, 32'(o_cmd_len), 32'd15);
    chk({tag, "_c1_last"}, 32'(o_cmd_last), 32'd1);
    expect_done(tag, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset       = 1'b1;
    i_start      = 1'b0;
    i_base_addr  = '0;
    i_img_width  = '0;
    i_img_height = '0;
    i_img_stride = '0;
    i_cmd_ready  = 1'b1;
    repeat (3) @(negedge aclk);
    tests += 7;
    if (o_cmd_valid !== 1'b0) begin failed++; $error("FAIL rst_valid: observed %0h expected 0", o_cmd_valid); end
    if (o_cmd_addr !== 32'h0) begin failed++; $error("FAIL rst_addr: observed %0h expected 0", o_cmd_addr); end
    if (o_cmd_len !== 8'h0) begin failed++; $error("FAIL rst_len: observed %0h expected 0", o_cmd_len); end
    if (o_cmd_last !== 1'b0) begin failed++; $error("FAIL rst_last: observed %0h expected 0", o_cmd_last); end
    if (o_busy !== 1'b0) begin failed++; $error("FAIL rst_busy: observed %0h expected 0", o_busy); end
    if (o_done !== 1'b0) begin failed++; $error("FAIL rst_done: observed %0h expected 0", o_done); end
    if (o_err !== 1'b0) begin failed++; $error("FAIL rst_err: observed %0h expected 0", o_err); end
    areset = 1'b0;

    scen1("basic");

    do_start(32'h2000, 32'd100, 32'd1, 32'd0);
    expect_cmd("split0", 32'h2000, 8'd15, 1'b0);
    expect_cmd("split1", 32'h2040, 8'd8, 1'b1);
    expect_done("split", 1'b0);

    do_start(32'h0FF8, 32'd32, 32'd1, 32'd0);
`ifdef DMA_BURST_4K_SPLIT_EN
    expect_cmd("b4k0", 32'h0FF8, 8'd1, 1'b0);
    expect_cmd("b4k1", 32'h1000, 8'd5, 1'b1);
`else
    expect_cmd("b4k0", 32'h0FF8, 8'd7, 1'b1);
`endif
    expect_done("b4k", 1'b0);

    i_cmd_ready = 1'b0;
    do_start(32'h1000, 32'd64, 32'd2, 32'd256);
    expect_cmd("bp0", 32'h1000, 8'd15, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      if (i == 1) begin
        i_base_addr  = 32'h5000;
        i_img_width  = 32'd8;
        i_img_height = 32'd1;
        i_start      = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge aclk);
      tests += 4;
      if (o_cmd_valid !== 1'b1) begin failed++; $error("FAIL bp_hold_valid: observed %0h expected 1", o_cmd_valid); end
      if (o_cmd_addr !== 32'h1000) begin failed++; $error("FAIL bp_hold_addr: observed %0h expected 1000", o_cmd_addr); end
      if (o_cmd_len !== 8'd15) begin failed++; $error("FAIL bp_hold_len: observed %0h expected f", o_cmd_len); end
      if (o_cmd_last !== 1'b0) begin failed++; $error("FAIL bp_hold_last: observed %0h expected 0", o_cmd_last); end
    end
    i_start     = 1'b0;
    i_cmd_ready = 1'b1;
    expect_cmd("bp1", 32'h1100, 8'd15, 1'b1);
    expect_done("bp", 1'b0);

    do_start(32'h3000, 32'd0, 32'd1, 32'd0);
    chk("err0_check_valid", 32'(o_cmd_valid), 32'd0);
    expect_done("err0", 1'b1);
    do_start(32'h3000, 32'd6, 32'd1, 32'd0);
    chk("err1_check_valid", 32'(o_cmd_valid), 32'd0);
    expect_done("err1", 1'b1);
    do_start(32'h2000, 32'd100, 32'd1, 32'd0);
    chk("err_clear", 32'(o_err), 32'd0);
    expect_cmd("rec0", 32'h2000, 8'd15, 1'b0);
    expect_cmd("rec1", 32'h2040, 8'd8, 1'b1);
    expect_done("rec", 1'b0);

    i_cmd_ready = 1'b0;
    do_start(32'h1000, 32'd64, 32'd2, 32'd256);
    expect_cmd("ra0", 32'h1000, 8'd15, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    chk("ra_valid", 32'(o_cmd_valid), 32'd0);
    chk("ra_busy", 32'(o_busy), 32'd0);
    chk("ra_done", 32'(o_done), 32'd0);
    areset      = 1'b0;
    i_cmd_ready = 1'b1;
    @(negedge aclk);
    chk("ra_post_done", 32'(o_done), 32'd0);
    chk("ra_post_busy", 32'(o_busy), 32'd0);
    scen1("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
